// File: rtl/riscv_hazard_pkg.sv
// Shared definitions for the pipeline hazard logic.
//
// Contents:
//    stall_state_t  - state encoding of the memory-wait FSM (RUN, MEM_WAIT)
//    REG_ZERO       - architectural x0, which never creates a dependency
//    PERF_CNT_W     - width of the optional performance counters
package riscv_hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } stall_state_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam int         PERF_CNT_W = 32;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the optional hazard performance counters.
//
// Parameters:
//    WIDTH  - counter width
// Ports:
//    clk    in   clock
//    rst_n  in   asynchronous active-low reset, clears the count
//    inc    in   count one event this cycle
//    clear  in   synchronous clear, takes priority over inc
//    count  out  current count, sticks at all-ones once reached
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

   // Once the counter reaches all-ones it holds there instead of wrapping,
   // so a long-running count never reads back as a small number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != COUNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Handles the hazards that
// forwarding cannot cover: load-use (one bubble), multi-cycle data-memory
// waits (with timeout) and taken-branch flushes.
//
// Parameters:
//    MEM_TIMEOUT  - max wait cycles in MEM_WAIT before abort (2..1023)
//    CNT_W        - wait counter width, 2**CNT_W > MEM_TIMEOUT
// Ports:
//    clk_i, rst_n_i            clock, asynchronous active-low reset
//    Rs1D_i, Rs2D_i            source registers of the instruction in D
//    RdE_i, LoadE_i            destination / load flag of the instruction in E
//    PCSrcE_i                  branch/jump taken, resolved in E
//    MemReqM_i, MemReadyM_i    data-memory request in M and its completion
//    StallF_o .. StallM_o      hold PC, F/D, D/E, E/M registers
//    FlushD_o, FlushE_o        clear F/D, D/E registers
//    FlushW_o                  clear M/W register (bubble into W)
//    MemErr_o                  one-cycle pulse after a memory timeout
// Optional feature (macro HAZARD_PERF_EN):
//    LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o  saturating 32-bit event counters
module hazard_stall_ctrl
   import riscv_hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [4:0]            Rs1D_i,
   input  logic [4:0]            Rs2D_i,
   input  logic [4:0]            RdE_i,
   input  logic                  LoadE_i,
   input  logic                  PCSrcE_i,
   input  logic                  MemReqM_i,
   input  logic                  MemReadyM_i,
   output logic                  StallF_o,
   output logic                  StallD_o,
   output logic                  StallE_o,
   output logic                  StallM_o,
   output logic                  FlushD_o,
   output logic                  FlushE_o,
   output logic                  FlushW_o,
`ifdef HAZARD_PERF_EN
   output logic [PERF_CNT_W-1:0] LoadUseCnt_o,
   output logic [PERF_CNT_W-1:0] MemWaitCnt_o,
   output logic [PERF_CNT_W-1:0] FlushCnt_o,
`endif
   output logic                  MemErr_o
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   stall_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             mem_stall;
   logic             lw_stall;

   // Memory stall is Mealy: it rises in the very cycle a request is seen
   // without ready, and falls in the cycle ready arrives or the wait budget
   // is used up.
   always_comb begin
      mem_stall = 1'b0;
      if (state == RUN) begin
         mem_stall = MemReqM_i & ~MemReadyM_i;
      end else begin
         mem_stall = ~MemReadyM_i & (cnt < WAIT_LAST);
      end
   end

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign lw_stall = LoadE_i & (RdE_i != REG_ZERO) &
                     ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));

   // A memory stall freezes E, so load-use and branch decisions are held off
   // until release. Otherwise a taken branch beats load-use: the dependent
   // instruction is being squashed anyway. Everything reads 0 while in reset.
   always_comb begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushW_o = 1'b0;
      if (rst_n_i) begin
         if (mem_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
         end else begin
            StallF_o = lw_stall & ~PCSrcE_i;
            StallD_o = lw_stall & ~PCSrcE_i;
            FlushD_o = PCSrcE_i;
            FlushE_o = lw_stall | PCSrcE_i;
         end
      end
   end

   // Memory-wait FSM. The counter restarts on every entry to MEM_WAIT; when
   // it reaches the last allowed cycle without ready, the wait is abandoned
   // and MemErr_o pulses for the following cycle. Reset simply returns to
   // RUN, so an interrupted wait never produces an error pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= RUN;
         cnt      <= '0;
         MemErr_o <= 1'b0;
      end else begin
         MemErr_o <= 1'b0;
         case (state)
            RUN: begin
               if (MemReqM_i && !MemReadyM_i) begin
                  state <= MEM_WAIT;
                  cnt   <= '0;
               end
            end
            MEM_WAIT: begin
               cnt <= cnt + 1'b1;
               if (MemReadyM_i) begin
                  state <= RUN;
               end else if (cnt == WAIT_LAST) begin
                  state    <= RUN;
                  MemErr_o <= 1'b1;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic lw_effective;
   logic flush_effective;

   // Only events that actually reach the pipeline are counted: a load-use
   // that is overridden by a branch or hidden behind a memory stall is not.
   assign lw_effective    = lw_stall & ~PCSrcE_i & ~mem_stall;
   assign flush_effective = PCSrcE_i & ~mem_stall;

   sat_counter #(.WIDTH(PERF_CNT_W)) u_load_use_cnt (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .inc   (lw_effective),
      .clear (1'b0),
      .count (LoadUseCnt_o)
   );

   sat_counter #(.WIDTH(PERF_CNT_W)) u_mem_wait_cnt (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .inc   (mem_stall),
      .clear (1'b0),
      .count (MemWaitCnt_o)
   );

   sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .inc   (flush_effective),
      .clear (1'b0),
      .count (FlushCnt_o)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT = 4).
// Output vector layout: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
module tb_hazard_stall_ctrl;

   localparam int NUM_VEC = 15;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic [4:0] Rs1D_i, Rs2D_i, RdE_i;
   logic       LoadE_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
   logic       StallF_o, StallD_o, StallE_o, StallM_o;
   logic       FlushD_o, FlushE_o, FlushW_o, MemErr_o;
   logic [7:0] actualOut;

`ifdef HAZARD_PERF_EN
   logic [31:0] LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o;
   logic        satInc;
   logic [2:0]  satCount;
`endif

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       load;
      logic       pcsrc;
      logic       memReq;
      logic       memReady;
      logic [7:0] expOut;
   } vector_t;

   vector_t vectors [NUM_VEC];

   always #5 clk_i = ~clk_i;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(10)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .Rs1D_i       (Rs1D_i),
      .Rs2D_i       (Rs2D_i),
      .RdE_i        (RdE_i),
      .LoadE_i      (LoadE_i),
      .PCSrcE_i     (PCSrcE_i),
      .MemReqM_i    (MemReqM_i),
      .MemReadyM_i  (MemReadyM_i),
      .StallF_o     (StallF_o),
      .StallD_o     (StallD_o),
      .StallE_o     (StallE_o),
      .StallM_o     (StallM_o),
      .FlushD_o     (FlushD_o),
      .FlushE_o     (FlushE_o),
      .FlushW_o     (FlushW_o),
`ifdef HAZARD_PERF_EN
      .LoadUseCnt_o (LoadUseCnt_o),
      .MemWaitCnt_o (MemWaitCnt_o),
      .FlushCnt_o   (FlushCnt_o),
`endif
      .MemErr_o     (MemErr_o)
   );

`ifdef HAZARD_PERF_EN
   sat_counter #(.WIDTH(3)) satDut (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .inc   (satInc),
      .clear (1'b0),
      .count (satCount)
   );
`endif

   assign actualOut = {StallF_o, StallD_o, StallE_o, StallM_o,
                       FlushD_o, FlushE_o, FlushW_o, MemErr_o};

   // Drive one cycle's inputs at the falling edge and let them settle.
   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic load,
                                input logic pcsrc, input logic memReq,
                                input logic memReady);
      @(negedge clk_i);
      Rs1D_i      = rs1;
      Rs2D_i      = rs2;
      RdE_i       = rd;
      LoadE_i     = load;
      PCSrcE_i    = pcsrc;
      MemReqM_i   = memReq;
      MemReadyM_i = memReady;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expOut);
      assertCount++;
      if (actualOut !== expOut) begin
         failCount++;
         $display("[TB] FAIL %s: got %b expected %b", name, actualOut, expOut);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      //                rs1    rs2    rd     ld    br    req   rdy   expected
      vectors[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
      vectors[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_0100};
      vectors[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
      vectors[3]  = '{5'd0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_1100};
      vectors[4]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1100};
      vectors[5]  = '{5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
      vectors[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1111_0010};
      vectors[7]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1111_0010};
      vectors[8]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'b1111_0010};
      vectors[9]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'b1100_0100};
      vectors[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0000};
      vectors[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
      vectors[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_1100};
      vectors[13] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1111_0010};
      vectors[14] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0000};

`ifdef HAZARD_PERF_EN
      satInc = 1'b0;
`endif

      // Reset with an active load-use and memory request: all outputs low.
      rst_n_i     = 1'b0;
      Rs1D_i      = 5'd5;
      Rs2D_i      = 5'd0;
      RdE_i       = 5'd5;
      LoadE_i     = 1'b1;
      PCSrcE_i    = 1'b1;
      MemReqM_i   = 1'b1;
      MemReadyM_i = 1'b0;
      #12;
      checkOutput("reset_state", 8'b0000_0000);
      @(negedge clk_i);
      LoadE_i   = 1'b0;
      PCSrcE_i  = 1'b0;
      MemReqM_i = 1'b0;
      rst_n_i   = 1'b1;

      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(vectors[i].rs1, vectors[i].rs2, vectors[i].rd,
                       vectors[i].load, vectors[i].pcsrc,
                       vectors[i].memReq, vectors[i].memReady);
         checkOutput($sformatf("vec%0d", i), vectors[i].expOut);
      end

      // Timeout: ready never arrives, four stall cycles then one error pulse.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("timeout_stall%0d", c), 8'b1111_0010);
      end
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("timeout_drop", 8'b0000_0000);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_err_pulse", 8'b0000_0001);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_err_gone", 8'b0000_0000);

      // Reset asserted during the second wait cycle.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("prereset_stall%0d", c), 8'b1111_0010);
      end
      rst_n_i = 1'b0;
      #1;
      checkOutput("reset_mid_wait", 8'b0000_0000);
      @(negedge clk_i);
      MemReqM_i = 1'b0;
      rst_n_i   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("postreset_idle%0d", c), 8'b0000_0000);
      end

`ifdef HAZARD_PERF_EN
      // Fresh counters: 2 load-use, 3 wait, 1 branch cycle.
      @(negedge clk_i);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkValue("perf_load_use", LoadUseCnt_o, 32'd2);
      checkValue("perf_mem_wait", MemWaitCnt_o, 32'd3);
      checkValue("perf_flush",    FlushCnt_o,   32'd1);

      // A narrow instance stands in for a near-full 32-bit counter.
      @(negedge clk_i);
      satInc = 1'b1;
      repeat (9) @(negedge clk_i);
      satInc = 1'b0;
      #1;
      checkValue("perf_saturate", {29'd0, satCount}, 32'd7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline; the producer-side counterpart of the forwarding unit.
- Where forwarding cannot deliver a value in time, this block freezes or bubbles stages:
  - load-use hazards (1-cycle stall);
  - multi-cycle data-memory waits (FSM with req/ready handshake and timeout);
  - taken-branch flushes.
- Sits beside the forwarding unit; drives the enables and clears of the F/D/E/M/W pipeline registers.

Parameters:
- MEM_TIMEOUT, 64, max wait cycles in MEM_WAIT before abort; legal range 2..1023.
- CNT_W, 10, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- Rs1D_i  in  5  rs1 of instruction in D
- Rs2D_i  in  5  rs2 of instruction in D
- RdE_i  in  5  rd of instruction in E
- LoadE_i  in  1  instruction in E is a load
- PCSrcE_i  in  1  branch/jump taken, resolved in E
- MemReqM_i  in  1  instruction in M accesses data memory
- MemReadyM_i  in  1  data memory completes the access this cycle
- StallF_o  out  1  hold PC
- StallD_o  out  1  hold F/D register
- StallE_o  out  1  hold D/E register
- StallM_o  out  1  hold E/M register
- FlushD_o  out  1  clear F/D register
- FlushE_o  out  1  clear D/E register
- FlushW_o  out  1  clear M/W register (bubble into W)
- MemErr_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: async; state <= RUN, wait counter <= 0, MemErr_o <= 0. While rst_n_i=0 all outputs read 0, including the combinational ones.
- FSM states: RUN, MEM_WAIT.
- memStall = (MemReqM_i & ~MemReadyM_i & state==RUN) | (state==MEM_WAIT & ~MemReadyM_i & cnt<MEM_TIMEOUT-1). It is Mealy: asserted in the same cycle the request is seen without ready.
- RUN -> MEM_WAIT: MemReqM_i=1 and MemReadyM_i=0; cnt <= 0.
- MEM_WAIT:
  - cnt increments each cycle.
  - MemReadyM_i=1: stall drops the same cycle, state -> RUN.
  - cnt==MEM_TIMEOUT-1 with no ready: stall drops, MemErr_o=1 for exactly the next cycle, state -> RUN.
- MemReq with ready in the same RUN cycle: zero stall, no state change.
- During memStall:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushD=FlushE=0, and load-use and branch are ignored (E is frozen, so they re-evaluate after release).
- lwStall = LoadE_i & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i). Register x0 never stalls.
- When no memStall:
  - StallF=StallD=lwStall & ~PCSrcE_i
  - FlushD=PCSrcE_i
  - FlushE=lwStall | PCSrcE_i
  - StallE=StallM=FlushW=0
- Simultaneous lwStall and PCSrcE_i: the branch wins (flush D and E, no stall).
- Load-use latency: exactly one bubble per load-use pair. No extra state; the next cycle the load is in M.
- Reset mid-MEM_WAIT: immediate return to RUN; no MemErr_o pulse.
- MemErr_o does not block the pipeline; it is only a pulse for the trap logic.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds three outputs, each 32 bits and saturating at 0xFFFFFFFF, reset to 0:
  - LoadUseCnt_o: cycles with lwStall effective.
  - MemWaitCnt_o: cycles with memStall.
  - FlushCnt_o: cycles with PCSrcE_i effective.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_hazard_pkg holds:
  - enum stall_state_t {RUN, MEM_WAIT};
  - REG_ZERO = 5'd0;
  - PERF_CNT_W = 32.
- Sub-module sat_counter (parameter width; inc/clear inputs; async active-low reset) is used for the perf counters under HAZARD_PERF_EN.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle. Same with RdE=0 -> all 0.
- Branch plus load-use: LoadE=1, RdE=3, Rs2D=3, PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF/D/E/M=FlushW=1 on those 3 cycles, 0 on the ready cycle, state RUN afterwards. A load-use condition held during the wait yields no FlushE until release.
- Timeout: MEM_TIMEOUT=4, ready never asserted -> stalls high for 4 cycles, then drop; MemErr_o=1 for exactly one cycle; state RUN.
- Reset mid-wait: assert rst_n_i=0 at wait cycle 2 -> all outputs 0 immediately; after release with MemReqM=0, no stall and MemErr_o stays 0.
- HAZARD_PERF_EN: 2 load-use + 3 wait + 1 branch cycles -> LoadUseCnt=2, MemWaitCnt=3, FlushCnt=1. Forced near-full counter saturates at 0xFFFFFFFF.
